// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM states, instruction field
// positions and PC width.
package instr_fetch_unit_pkg;

    localparam int unsigned PC_W       = 32;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned TARGET_MSB = 25;
    localparam int unsigned IMM_MSB    = 15;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// Next-PC selection: jump beats taken branch, which beats sequential pc+4.
// All arithmetic is 32-bit modular.
module next_pc_logic
    import instr_fetch_unit_pkg::*;
(
    input  logic [PC_W-1:0]       pc_plus4,
    input  logic [TARGET_MSB:0]   instr,
    input  logic                  branch,
    input  logic                  jump,
    input  logic                  zero,
    output logic [PC_W-1:0]       next_pc
);

    logic [PC_W-1:0] branch_off;

    assign branch_off = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[TARGET_MSB:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ready handshake, holds the
// instruction for the control unit until the datapath reports completion.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [5:0]      opcode,
    output logic [5:0]      funct,
    output logic [31:0]     pc,
    output logic [31:0]     pc_plus4,
    input  logic            exec_done,
    input  logic            branch,
    input  logic            jump,
    input  logic            zero,
    output logic            fetch_err
);

    localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [PC_W-1:0]  next_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    state_nxt = ISSUE;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = HALT;
                end
            end
            ISSUE: begin
                if (exec_done) begin
                    state_nxt = FETCH;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        wait_cnt    <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        fetch_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    next_pc_logic u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr[TARGET_MSB:0]),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    // Gated by rst so the request drops immediately, without waiting for an edge.
    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
    assign funct     = instr[FUNCT_MSB:FUNCT_LSB];

endmodule
